fft_pingpong_ram: RTL and testbench

FFT_PINGPONG_RAM -- requirements
Module: fft_pingpong_ram

---
 rtl/fft_ram_pkg.sv | 22 ++
 rtl/ram_bank.sv | 46 ++++
 rtl/fft_pingpong_ram.sv | 110 +++++++++++
 tb/tb_fft_pingpong_ram.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fft_ram_pkg.sv
// Shared constants and helpers for the ping-pong FFT frame buffer.
// The bit-reverse helper works on a fixed-width vector so any bank width can reuse it.
package fft_ram_pkg;

  localparam int unsigned DefaultDataW = 32;
  localparam int unsigned DefaultAddrW = 10;
  localparam int unsigned MaxAddrW     = 32;

  // Reverse the low `width` bits of addr; bits at or above `width` come back as zero.
  function automatic logic [MaxAddrW-1:0] bit_reverse(input logic [MaxAddrW-1:0] addr,
                                                      input int unsigned         width);
    logic [MaxAddrW-1:0] rev;
    rev = '0;
    for (int unsigned i = 0; i < MaxAddrW; i++) begin
      if (i < width) begin
        rev[5'(width - 1 - i)] = addr[5'(i)];
      end
    end
    return rev;
  endfunction

endpackage

// File: rtl/ram_bank.sv
// Simple dual-port bank: one synchronous write port and one registered read port.
// Storage is never reset; only the read register clears, so data_out starts at zero.
module ram_bank
  import fft_ram_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned ADDR_W = DefaultAddrW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // The read register holds its value when no read is issued.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[raddr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fft_pingpong_ram.sv
// Two-bank ping-pong frame buffer: a writer fills one bank while a reader drains the other.
// Bank selection, full flags, handshakes and the sticky error flag live here.
module fft_pingpong_ram
  import fft_ram_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned ADDR_W = DefaultAddrW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              wr_done,
  input  logic              read_en,
  input  logic [ADDR_W-1:0] read_addr,
  input  logic              rd_bitrev,
  input  logic              rd_done,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              wr_ready,
  output logic              rd_ready,
  output logic              wr_bank,
  output logic              rd_bank,
  output logic              err
);

  logic [1:0]        full_q, full_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic              rd_sel_q, rd_sel_d;
  logic              rd_valid_q, rd_valid_d;
  logic              err_q, err_d;
  logic              wr_acc, rd_acc;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rdata [2];

  always_comb begin
    wr_ready = !full_q[wr_bank_q];
    rd_ready = full_q[rd_bank_q];
    wr_acc   = write_en && wr_ready;
    rd_acc   = read_en && rd_ready;
    rd_addr  = rd_bitrev ? ADDR_W'(bit_reverse(MaxAddrW'(read_addr), ADDR_W)) : read_addr;
  end

  // A writable bank is empty and a readable bank is full, so both done pulses always
  // target different banks and can be applied independently.
  always_comb begin
    full_d     = full_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    rd_sel_d   = rd_sel_q;
    rd_valid_d = rd_acc;
    err_d      = err_q | (write_en & ~wr_ready) | (read_en & ~rd_ready);
    if (wr_done && wr_ready) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
    end
    if (rd_done && rd_ready) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
    if (rd_acc) begin
      rd_sel_d = rd_bank_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q     <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      rd_sel_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      full_q     <= full_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      rd_sel_q   <= rd_sel_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    ram_bank #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
    ) u_bank (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_acc && (wr_bank_q == 1'(b))),
      .waddr (write_addr),
      .wdata (data_in),
      .re    (rd_acc && (rd_bank_q == 1'(b))),
      .raddr (rd_addr),
      .rdata (rdata[b])
    );
  end

  // Each bank's read register holds its last value, so muxing by the last-read bank
  // keeps data_out stable between reads.
  assign data_out = rd_sel_q ? rdata[1] : rdata[0];
  assign rd_valid = rd_valid_q;
  assign wr_bank  = wr_bank_q;
  assign rd_bank  = rd_bank_q;
  assign err      = err_q;

endmodule

// File: tb/tb_fft_pingpong_ram.sv
// Bench for fft_pingpong_ram: directed frame scenarios plus random traffic, checked
// every cycle against a frame-level model of the two banks.
module tb_fft_pingpong_ram;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 2;
  localparam int unsigned Depth = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          write_en = 1'b0, wr_done = 1'b0, read_en = 1'b0, rd_bitrev = 1'b0;
  logic          rd_done = 1'b0;
  logic [AW-1:0] write_addr = '0, read_addr = '0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          rd_valid, wr_ready, rd_ready, wr_bank, rd_bank, err;

  always #5 clk = ~clk;

  fft_pingpong_ram #(
    .DATA_W(DW),
    .ADDR_W(AW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .write_en   (write_en),
    .write_addr (write_addr),
    .data_in    (data_in),
    .wr_done    (wr_done),
    .read_en    (read_en),
    .read_addr  (read_addr),
    .rd_bitrev  (rd_bitrev),
    .rd_done    (rd_done),
    .data_out   (data_out),
    .rd_valid   (rd_valid),
    .wr_ready   (wr_ready),
    .rd_ready   (rd_ready),
    .wr_bank    (wr_bank),
    .rd_bank    (rd_bank),
    .err        (err)
  );

  // Reference model: frames held per bank, plus which words are known to be written.
  logic [DW-1:0] m_mem   [2][Depth];
  bit            m_known [2][Depth];
  bit            m_full  [2];
  bit            m_wb, m_rb, m_err, m_v, m_do_known;
  logic [DW-1:0] m_do;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_full[0] = 0; m_full[1] = 0;
    m_wb = 0; m_rb = 0; m_err = 0; m_v = 0;
    m_do = '0; m_do_known = 1;
  endtask

  task automatic model_step();
    bit            can_wr, can_rd;
    logic [AW-1:0] a;
    can_wr = !m_full[m_wb];
    can_rd = m_full[m_rb];
    a = rd_bitrev ? {read_addr[0], read_addr[1]} : read_addr;
    m_v = read_en && can_rd;
    if (m_v) begin
      m_do       = m_mem[m_rb][a];
      m_do_known = m_known[m_rb][a];
    end
    if (write_en && can_wr) begin
      m_mem[m_wb][write_addr]   = data_in;
      m_known[m_wb][write_addr] = 1;
    end
    if ((write_en && !can_wr) || (read_en && !can_rd)) m_err = 1;
    if (wr_done && can_wr) begin
      m_full[m_wb] = 1;
      m_wb = !m_wb;
    end
    if (rd_done && can_rd) begin
      m_full[m_rb] = 0;
      m_rb = !m_rb;
    end
  endtask

  task automatic compare_all();
    check("wr_ready", 32'(wr_ready), 32'(!m_full[m_wb]));
    check("rd_ready", 32'(rd_ready), 32'(m_full[m_rb]));
    check("wr_bank", 32'(wr_bank), 32'(m_wb));
    check("rd_bank", 32'(rd_bank), 32'(m_rb));
    check("err", 32'(err), 32'(m_err));
    check("rd_valid", 32'(rd_valid), 32'(m_v));
    if (m_do_known) check("data_out", data_out, m_do);
  endtask

  task automatic cyc(input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] din,
                     input bit wd, input bit re, input logic [AW-1:0] ra, input bit rev,
                     input bit rdn);
    @(negedge clk);
    write_en = we; write_addr = wa; data_in = din; wr_done = wd;
    read_en = re; read_addr = ra; rd_bitrev = rev; rd_done = rdn;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    write_en = 0; wr_done = 0; read_en = 0; rd_done = 0;
    rst_n = 0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    cyc(1, a, d, 0, 0, 0, 0, 0);
  endtask

  task automatic done_w();
    cyc(0, 0, 0, 1, 0, 0, 0, 0);
  endtask

  task automatic rd(input logic [AW-1:0] a, input bit rev, input bit rdn);
    cyc(0, 0, 0, 0, 1, a, rev, rdn);
  endtask

  task automatic fill(input logic [DW-1:0] base);
    for (int i = 0; i < Depth; i++) wr(AW'(i), base + DW'(i));
    done_w();
  endtask

  logic [DW-1:0] frame0 [Depth];
  logic [DW-1:0] brv0   [Depth];

  initial begin
    frame0 = '{32'h11, 32'h22, 32'h33, 32'h44};
    brv0   = '{32'h11, 32'h33, 32'h22, 32'h44};

    // Reset then idle
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    rst_n = 1;
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    check("idle_wr_ready", 32'(wr_ready), 32'd1);
    check("idle_rd_ready", 32'(rd_ready), 32'd0);
    check("idle_data_out", data_out, 32'd0);
    check("idle_err", 32'(err), 32'd0);

    // One frame, linear then bit-reversed readback
    for (int i = 0; i < Depth; i++) wr(AW'(i), frame0[i]);
    done_w();
    check("frame_wr_bank", 32'(wr_bank), 32'd1);
    check("frame_rd_ready", 32'(rd_ready), 32'd1);
    for (int i = 0; i < Depth; i++) begin
      rd(AW'(i), 0, 0);
      check("lin_valid", 32'(rd_valid), 32'd1);
      check("lin_data", data_out, frame0[i]);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    check("hold_valid", 32'(rd_valid), 32'd0);
    check("hold_data", data_out, 32'h44);
    for (int i = 0; i < Depth; i++) begin
      rd(AW'(i), 1, 0);
      check("rev_data", data_out, brv0[i]);
    end

    // Both banks full: stray write rejected, both frames intact
    fill(32'hA0);
    check("both_full_wr_ready", 32'(wr_ready), 32'd0);
    wr(0, 32'hDEAD_BEEF);
    check("overflow_err", 32'(err), 32'd1);
    for (int i = 0; i < Depth; i++) begin
      rd(AW'(i), 0, i == Depth - 1);  // release on the last read still returns bank 0 data
      check("bank0_keep", data_out, frame0[i]);
    end
    for (int i = 0; i < Depth; i++) begin
      rd(AW'(i), 0, i == Depth - 1);
      check("bank1_keep", data_out, 32'hA0 + DW'(i));
    end
    check("drained_rd_ready", 32'(rd_ready), 32'd0);

    // Simultaneous wr_done and rd_done
    do_reset();
    fill(32'h100);
    wr(0, 32'h200);
    wr(1, 32'h201);
    cyc(0, 0, 0, 1, 0, 0, 0, 1);
    check("sim_wr_bank", 32'(wr_bank), 32'd0);
    check("sim_rd_bank", 32'(rd_bank), 32'd1);
    check("sim_wr_ready", 32'(wr_ready), 32'd1);
    check("sim_rd_ready", 32'(rd_ready), 32'd1);

    // Reset mid-fill abandons everything
    do_reset();
    fill(32'h300);
    wr(0, 32'h400);
    do_reset();
    check("post_rst_rd_ready", 32'(rd_ready), 32'd0);
    rd(0, 0, 0);
    check("post_rst_err", 32'(err), 32'd1);
    check("post_rst_valid", 32'(rd_valid), 32'd0);

    // Random traffic
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        cyc($urandom_range(0, 2) != 0, AW'($urandom), $urandom,
            $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1, AW'($urandom),
            $urandom_range(0, 1) == 1, $urandom_range(0, 6) == 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
